irq_vector_ctrl: RTL and testbench

- Parametrised interrupt controller that produces the `vector` input consumed by the pipelined `cpu` core.
- Replaces the constant vector currently driven from the top-level bench.
- Collects N_CH interrupt lines with per-channel mask and edge/level mode, and selects the highest-priority pending channel.
- Presents a stable vector under a req/ack handshake, then tracks in-service state until end-of-interrupt.

---
 rtl/citrus_intc_pkg.sv | 28 ++
 rtl/intc_prio_enc.sv | 29 ++
 rtl/irq_vector_ctrl.sv | 170 +++++++++++++++++
 tb/tb_irq_vector_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/citrus_intc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : citrus_intc_pkg
// Purpose  : Shared definitions for the interrupt vector controller:
//            controller state encoding, configuration-target select codes
//            and the vector arithmetic helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package citrus_intc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic CFG_MASK = 1'b0;
  localparam logic CFG_MODE = 1'b1;

  // Vector of a channel before truncation to the output width; the caller
  // narrows the result, which gives the modulo-2^VEC_W wrap.
  function automatic int calc_vector(input int base, input int idx, input int stride);
    return base + idx * stride;
  endfunction

endpackage
`default_nettype wire

// File: rtl/intc_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : intc_prio_enc
// Purpose  : Combinational fixed-priority encoder, lowest index wins.
// Ports    : req   - request vector, N_CH bits
//            valid - at least one request bit set
//            idx   - index of the lowest set request bit (0 when none)
// Revision : 1.0 - initial release
// ============================================================================
module intc_prio_enc #(
  parameter int N_CH  = 8,
  parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the last (lowest) set bit overwrites.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_vector_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_vector_ctrl
// Purpose  : N_CH-channel interrupt controller producing the CPU vector.
//            Per-channel mask and edge/level mode, fixed lowest-index
//            priority, req/ack handshake and in-service tracking until eoi.
// Ports    : clk        - system clock, rising edge
//            clr        - synchronous active-high reset
//            irq        - raw interrupt lines
//            cfg_we     - configuration write strobe
//            cfg_sel    - 0: mask register, 1: mode register (1 = edge)
//            cfg_wdata  - configuration write data
//            int_req    - interrupt request to the CPU
//            int_vector - vector of the requested channel
//            int_ack    - CPU accepts the current request
//            eoi        - CPU end-of-interrupt
//            pending    - pending register
//            in_service - one-hot in-service channel, or 0
// Revision : 1.0 - initial release
// ============================================================================
module irq_vector_ctrl
  import citrus_intc_pkg::*;
#(
  parameter int               N_CH       = 8,
  parameter int               VEC_W      = 8,
  parameter logic [VEC_W-1:0] VEC_BASE   = '0,
  parameter int               VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_CH-1:0]  irq,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [N_CH-1:0]  cfg_wdata,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vector,
  input  logic             int_ack,
  input  logic             eoi,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  in_service
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]  r_mask;
  logic [N_CH-1:0]  r_mode;
  logic [N_CH-1:0]  r_irq_d;
  logic [N_CH-1:0]  r_pending;
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_int_req;
  logic [VEC_W-1:0] r_int_vector;
  logic [N_CH-1:0]  r_in_service;

  logic [N_CH-1:0]  w_rise;
  logic [N_CH-1:0]  w_eligible;
  logic             w_enc_valid;
  logic [IDX_W-1:0] w_enc_idx;
  logic [VEC_W-1:0] w_vec;
  logic [N_CH-1:0]  w_onehot;
  logic             w_withdraw;
  logic [N_CH-1:0]  w_mode_chg;
  logic [N_CH-1:0]  w_ack_clr;
  logic [N_CH-1:0]  w_pending_n;
  state_t           w_state_n;
  logic [IDX_W-1:0] w_idx_n;
  logic             w_req_n;
  logic [VEC_W-1:0] w_vec_n;
  logic [N_CH-1:0]  w_insvc_n;

  assign w_rise     = irq & ~r_irq_d;
  assign w_eligible = r_pending & ~r_mask;
  assign w_onehot   = N_CH'(1) << r_idx;
  assign w_vec      = VEC_W'(calc_vector(int'(VEC_BASE), int'(w_enc_idx), VEC_STRIDE));

  // The latched request goes away when its channel becomes masked or, for a
  // level channel, when its (registered) line has dropped.
  assign w_withdraw = r_mask[r_idx] | (~r_mode[r_idx] & ~r_pending[r_idx]);

  // Any channel whose mode flips this cycle loses its pending bit.
  assign w_mode_chg = (cfg_we && (cfg_sel == CFG_MODE)) ? (cfg_wdata ^ r_mode) : '0;

  intc_prio_enc #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req   (w_eligible),
    .valid (w_enc_valid),
    .idx   (w_enc_idx)
  );

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_req_n   = r_int_req;
    w_vec_n   = r_int_vector;
    w_insvc_n = r_in_service;
    w_ack_clr = '0;
    unique case (r_state)
      IDLE: begin
        if (w_enc_valid) begin
          w_state_n = REQ;
          w_idx_n   = w_enc_idx;
          w_req_n   = 1'b1;
          w_vec_n   = w_vec;
        end
      end
      REQ: begin
        // Ack takes precedence over withdrawal.
        if (int_ack) begin
          w_state_n = SERVICE;
          w_req_n   = 1'b0;
          w_insvc_n = w_onehot;
          w_ack_clr = w_onehot & r_mode;
        end else if (w_withdraw) begin
          w_state_n = IDLE;
          w_req_n   = 1'b0;
        end
      end
      SERVICE: begin
        if (eoi) begin
          w_state_n = IDLE;
          w_insvc_n = '0;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_req_n   = 1'b0;
        w_insvc_n = '0;
      end
    endcase
  end

  // Edge channels: a new rise beats the ack clear. Level channels mirror irq.
  assign w_pending_n = ((r_mode & ((r_pending & ~w_ack_clr) | w_rise)) |
                        (~r_mode & irq)) & ~w_mode_chg;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_mask       <= '1;
      r_mode       <= '0;
      r_irq_d      <= '0;
      r_pending    <= '0;
      r_state      <= IDLE;
      r_idx        <= '0;
      r_int_req    <= 1'b0;
      r_int_vector <= '0;
      r_in_service <= '0;
    end else begin
      r_irq_d      <= irq;
      r_pending    <= w_pending_n;
      r_state      <= w_state_n;
      r_idx        <= w_idx_n;
      r_int_req    <= w_req_n;
      r_int_vector <= w_vec_n;
      r_in_service <= w_insvc_n;
      if (cfg_we) begin
        if (cfg_sel == CFG_MODE) r_mode <= cfg_wdata;
        else                     r_mask <= cfg_wdata;
      end
    end
  end

  assign int_req    = r_int_req;
  assign int_vector = r_int_vector;
  assign pending    = r_pending;
  assign in_service = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_irq_vector_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_vector_ctrl
// Purpose  : Self-checking bench for irq_vector_ctrl: directed scenarios with
//            fixed expected values, then randomized traffic compared each
//            cycle against a behavioural model of the controller.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_vector_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic [7:0] irq;
  logic       cfg_we;
  logic       cfg_sel;
  logic [7:0] cfg_wdata;
  logic       int_ack;
  logic       eoi;
  logic       int_req;
  logic [7:0] int_vector;
  logic [7:0] pending;
  logic [7:0] in_service;

  logic [15:0] irq16;
  logic        we16;
  logic        sel16;
  logic [15:0] wdata16;
  logic        ack16;
  logic        eoi16;
  logic        req16;
  logic [7:0]  vec16;
  logic [15:0] pend16;
  logic [15:0] insvc16;

  irq_vector_ctrl #(
    .N_CH(8), .VEC_W(8), .VEC_BASE(8'h00), .VEC_STRIDE(4)
  ) u_dut (
    .clk(clk), .clr(clr), .irq(irq), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .int_req(int_req), .int_vector(int_vector),
    .int_ack(int_ack), .eoi(eoi), .pending(pending), .in_service(in_service)
  );

  irq_vector_ctrl #(
    .N_CH(16), .VEC_W(8), .VEC_BASE(8'hF0), .VEC_STRIDE(4)
  ) u_dut16 (
    .clk(clk), .clr(clr), .irq(irq16), .cfg_we(we16), .cfg_sel(sel16),
    .cfg_wdata(wdata16), .int_req(req16), .int_vector(vec16),
    .int_ack(ack16), .eoi(eoi16), .pending(pend16), .in_service(insvc16)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of the 8-channel instance. The controller is idle when
  // nothing is requested and nothing is in service.
  bit [7:0] m_mask, m_mode, m_irqd, m_pend, m_insvc, m_vec;
  bit       m_req;
  int       m_idx;

  task automatic model_step();
    bit [7:0] elig;
    bit [7:0] np;
    bit [7:0] ninsvc;
    bit       nreq;
    bit       acked;
    bit       rise;
    bit       chg;
    int       first;
    if (clr) begin
      m_mask = 8'hFF; m_mode = 8'h00; m_irqd = 8'h00; m_pend = 8'h00;
      m_req = 1'b0; m_vec = 8'h00; m_insvc = 8'h00; m_idx = 0;
      return;
    end
    elig   = m_pend & ~m_mask;
    nreq   = m_req;
    ninsvc = m_insvc;
    acked  = 1'b0;
    if (!m_req && m_insvc == 8'h00) begin
      if (elig != 8'h00) begin
        first = -1;
        for (int i = 7; i >= 0; i--) if (elig[i]) first = i;
        nreq  = 1'b1;
        m_idx = first;
        m_vec = 8'((0 + first * 4) % 256);
      end
    end else if (m_req) begin
      if (int_ack) begin
        acked  = 1'b1;
        nreq   = 1'b0;
        ninsvc = 8'h01 << m_idx;
      end else if (m_mask[m_idx] || (!m_mode[m_idx] && !m_pend[m_idx])) begin
        nreq = 1'b0;
      end
    end else if (eoi) begin
      ninsvc = 8'h00;
    end
    for (int i = 0; i < 8; i++) begin
      rise = irq[i] && !m_irqd[i];
      chg  = cfg_we && cfg_sel && (cfg_wdata[i] != m_mode[i]);
      if (chg)            np[i] = 1'b0;
      else if (m_mode[i]) np[i] = rise ? 1'b1 : ((acked && i == m_idx) ? 1'b0 : m_pend[i]);
      else                np[i] = irq[i];
    end
    if (cfg_we) begin
      if (cfg_sel) m_mode = cfg_wdata;
      else         m_mask = cfg_wdata;
    end
    m_irqd  = irq;
    m_pend  = np;
    m_req   = nreq;
    m_insvc = ninsvc;
  endtask

  // One clock: model follows the edge, DUT is compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("model_req", {31'd0, int_req}, {31'd0, m_req});
    check("model_pending", {24'd0, pending}, {24'd0, m_pend});
    check("model_in_service", {24'd0, in_service}, {24'd0, m_insvc});
    if (m_req) check("model_vector", {24'd0, int_vector}, {24'd0, m_vec});
  endtask

  task automatic cfg_write(input logic sel, input logic [7:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
    cyc();
    cfg_we = 1'b0;
  endtask

  initial begin
    clr = 1'b1; irq = '0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_wdata = '0;
    int_ack = 1'b0; eoi = 1'b0;
    irq16 = '0; we16 = 1'b0; sel16 = 1'b0; wdata16 = '0; ack16 = 1'b0; eoi16 = 1'b0;
    cyc(); cyc();
    check("rst_req", {31'd0, int_req}, 32'd0);
    check("rst_vector", {24'd0, int_vector}, 32'h00);
    check("rst_pending", {24'd0, pending}, 32'h00);
    check("rst_in_service", {24'd0, in_service}, 32'h00);
    clr = 1'b0;

    // Basic edge path
    cfg_write(1'b0, 8'h00);
    cfg_write(1'b1, 8'hFF);
    irq = 8'h08; cyc();
    irq = 8'h00; cyc();
    check("edge_req", {31'd0, int_req}, 32'd1);
    check("edge_vector", {24'd0, int_vector}, 32'h0C);
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
    check("edge_pend3_clr", {31'd0, pending[3]}, 32'd0);
    check("edge_in_service", {24'd0, in_service}, 32'h08);
    check("edge_req_drop", {31'd0, int_req}, 32'd0);
    eoi = 1'b1; cyc(); eoi = 1'b0;
    check("edge_eoi_insvc", {24'd0, in_service}, 32'h00);
    cyc();
    check("edge_no_rereq", {31'd0, int_req}, 32'd0);

    // Priority and stability
    irq = 8'h24; cyc();
    irq = 8'h00; cyc();
    check("prio_vector", {24'd0, int_vector}, 32'h08);
    irq = 8'h01; cyc();
    irq = 8'h00; cyc();
    check("prio_stable", {24'd0, int_vector}, 32'h08);
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
    eoi = 1'b1; cyc(); eoi = 1'b0;
    cyc();
    check("prio_next0", {24'd0, int_vector}, 32'h00);
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
    eoi = 1'b1; cyc(); eoi = 1'b0;
    cyc();
    check("prio_next5", {24'd0, int_vector}, 32'h14);
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
    eoi = 1'b1; cyc(); eoi = 1'b0;

    // Level and withdraw
    cfg_write(1'b1, 8'h00);
    irq = 8'h02; cyc(); cyc();
    check("level_req", {31'd0, int_req}, 32'd1);
    check("level_vector", {24'd0, int_vector}, 32'h04);
    irq = 8'h00; cyc(); cyc();
    check("withdraw_req", {31'd0, int_req}, 32'd0);
    check("withdraw_insvc", {24'd0, in_service}, 32'h00);
    cyc();
    check("withdraw_idle", {31'd0, int_req}, 32'd0);

    // Masking
    cfg_write(1'b0, 8'hFF);
    cfg_write(1'b1, 8'hFF);
    irq = 8'h40; cyc();
    irq = 8'h00; cyc(); cyc();
    check("mask_no_req", {31'd0, int_req}, 32'd0);
    check("mask_pend6", {31'd0, pending[6]}, 32'd1);
    cfg_write(1'b0, 8'h00);
    check("mask_same_cycle", {31'd0, int_req}, 32'd0);
    cyc();
    check("unmask_req", {31'd0, int_req}, 32'd1);
    check("unmask_vector", {24'd0, int_vector}, 32'h18);
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
    eoi = 1'b1; cyc(); eoi = 1'b0;

    // Wider instance with wrapping vector arithmetic
    we16 = 1'b1; sel16 = 1'b0; wdata16 = 16'h0000; cyc();
    sel16 = 1'b1; wdata16 = 16'hFFFF; cyc();
    we16 = 1'b0;
    irq16 = 16'h0080; cyc();
    irq16 = 16'h0000; cyc();
    check("p16_req", {31'd0, req16}, 32'd1);
    check("p16_vector", {24'd0, vec16}, 32'h0C);
    check("p16_pending", {16'd0, pend16}, 32'h0080);
    ack16 = 1'b1; cyc(); ack16 = 1'b0;
    check("p16_insvc", {16'd0, insvc16}, 32'h0080);
    eoi16 = 1'b1; cyc(); eoi16 = 1'b0;

    // Reset during REQ
    irq = 8'h10; cyc();
    irq = 8'h00; cyc();
    check("rreq_req", {31'd0, int_req}, 32'd1);
    clr = 1'b1; cyc();
    check("rreq_req0", {31'd0, int_req}, 32'd0);
    check("rreq_pend0", {24'd0, pending}, 32'h00);
    check("rreq_insvc0", {24'd0, in_service}, 32'h00);
    irq = 8'h01; cyc();
    irq = 8'h00; cyc();
    clr = 1'b0; cyc();
    check("rclr_edge_lost", {24'd0, pending}, 32'h00);

    // Reset during SERVICE
    cfg_write(1'b0, 8'h00);
    cfg_write(1'b1, 8'hFF);
    irq = 8'h04; cyc();
    irq = 8'h00; cyc();
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
    check("rsvc_insvc", {24'd0, in_service}, 32'h04);
    clr = 1'b1; cyc(); clr = 1'b0;
    check("rsvc_insvc0", {24'd0, in_service}, 32'h00);
    check("rsvc_req0", {31'd0, int_req}, 32'd0);
    irq = 8'h08; cyc(); cyc(); cyc();
    check("rst_masked_pend", {24'd0, pending}, 32'h08);
    check("rst_masked_noreq", {31'd0, int_req}, 32'd0);
    irq = 8'h00; cyc();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      irq       = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      cfg_we    = ($urandom_range(0, 19) == 0);
      cfg_sel   = 1'($urandom_range(0, 1));
      cfg_wdata = 8'($urandom);
      int_ack   = ($urandom_range(0, 2) == 0);
      eoi       = ($urandom_range(0, 3) == 0);
      clr       = ($urandom_range(0, 399) == 0);
      cyc();
    end
    clr = 1'b0; cfg_we = 1'b0; int_ack = 1'b0; eoi = 1'b0; irq = '0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
